// File: rtl/contador_modular_multidigito_if.sv
// Bus interface for contador_modular_multidigito: control, load data and count outputs.
// Optional macro SEG7_DISPLAY_EN adds the seven-segment output seg.
interface contador_modular_multidigito_if #(
    parameter int unsigned NDIGITS = 2,
    parameter int unsigned DIGIT_W = 4
);
    logic                       enable;
    logic                       count_up;
    logic                       saturate;
    logic                       load;
    logic [NDIGITS*DIGIT_W-1:0] data_in;
    logic [NDIGITS*DIGIT_W-1:0] count;
    logic                       terminal;
    logic                       wrap;
`ifdef SEG7_DISPLAY_EN
    logic [7:0]                 seg;
`endif

    // Master drives the controls and observes the counter.
    modport master (
        output enable, count_up, saturate, load, data_in,
`ifdef SEG7_DISPLAY_EN
        input  seg,
`endif
        input  count, terminal, wrap
    );

    // Slave is the counter itself.
    modport slave (
        input  enable, count_up, saturate, load, data_in,
`ifdef SEG7_DISPLAY_EN
        output seg,
`endif
        output count, terminal, wrap
    );
endinterface

// File: rtl/contador_modular_multidigito.sv
// Multi-digit modulo-MODULUS up/down counter with parallel load, saturate/wrap mode,
// combinational terminal flag and registered wrap pulse.
// Optional macro SEG7_DISPLAY_EN: adds a seven-segment decode of digit 0 on bus.seg.
module contador_modular_multidigito #(
    parameter int unsigned NDIGITS = 2,
    parameter int unsigned MODULUS = 10,
    parameter int unsigned DIGIT_W = 4
) (
    input logic                            clk_2,
    input logic                            reset,
    contador_modular_multidigito_if.slave  bus
);
    localparam int unsigned            W        = NDIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0]     MaxDigit = DIGIT_W'(MODULUS - 1);

    logic [W-1:0]       count_q, count_d;
    logic               wrap_q, wrap_d;
    logic               terminal;
    logic               term_up, term_dn;
    logic               carry;
    logic [DIGIT_W-1:0] digit;

    // Terminal detection: all digits at the extreme for the current direction.
    always_comb begin
        term_up = 1'b1;
        term_dn = 1'b1;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (count_q[i*DIGIT_W +: DIGIT_W] != MaxDigit) term_up = 1'b0;
            if (count_q[i*DIGIT_W +: DIGIT_W] != '0)       term_dn = 1'b0;
        end
        terminal = bus.count_up ? term_up : term_dn;
    end

    // Next-state: load (with per-digit clamp) beats enable; carry ripples from digit 0.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        digit   = '0;
        if (bus.load) begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                digit = bus.data_in[i*DIGIT_W +: DIGIT_W];
                if (32'(digit) >= MODULUS) digit = MaxDigit;
                count_d[i*DIGIT_W +: DIGIT_W] = digit;
            end
        end else if (bus.enable && !(terminal && bus.saturate)) begin
            // At the terminal value the natural ripple already wraps every digit.
            wrap_d = terminal;
            carry  = 1'b1;
            for (int i = 0; i < int'(NDIGITS); i++) begin
                digit = count_q[i*DIGIT_W +: DIGIT_W];
                if (carry) begin
                    if (bus.count_up) begin
                        count_d[i*DIGIT_W +: DIGIT_W] =
                            (digit == MaxDigit) ? '0 : digit + DIGIT_W'(1);
                    end else begin
                        count_d[i*DIGIT_W +: DIGIT_W] =
                            (digit == '0) ? MaxDigit : digit - DIGIT_W'(1);
                    end
                end
                carry = carry && (bus.count_up ? (digit == MaxDigit) : (digit == '0));
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_2) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.terminal = terminal;
    assign bus.wrap     = wrap_q;

`ifdef SEG7_DISPLAY_EN
    logic [3:0] nibble;
    logic [6:0] segs;

    // Hex seven-segment decode of digit 0, segment a on bit 0.
    always_comb begin
        nibble = 4'(count_q[DIGIT_W-1:0]);
        segs   = 7'h00;
        case (nibble)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            default: segs = 7'h71;
        endcase
    end

    assign bus.seg = {wrap_q, segs};
`endif
endmodule

// File: doc/contador_modular_multidigito.md
Name: contador_modular_multidigito

Overview:
Parametrised synchronous up/down counter built from NDIGITS cascaded digits, each counting modulo MODULUS. It supports parallel load, clock enable, direction select and a wrap/saturate mode, and flags terminal count and wrap-around. It sits between the board switch/LED/SEG top level and any logic that needs a multi-digit decimal or arbitrary-modulus count, such as timers or display counters.

Parameters:
NDIGITS, 2, number of cascaded digits; must be >= 1.
MODULUS, 10, count range per digit is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**DIGIT_W.
DIGIT_W, 4, bit width of one digit.

Ports:
clk_2  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous reset, active-low (0 = reset), sampled on the clk_2 rising edge.
enable  input  1  count enable.
count_up  input  1  direction: 1 = up, 0 = down.
saturate  input  1  1 = hold at the terminal value; 0 = wrap around.
load  input  1  synchronous parallel load.
data_in  input  NDIGITS*DIGIT_W  load value; digit i occupies bits [i*DIGIT_W +: DIGIT_W], digit 0 is least significant.
count  output  NDIGITS*DIGIT_W  current count, same digit packing as data_in.
terminal  output  1  combinational terminal-count flag.
wrap  output  1  registered wrap-around pulse.

Behaviour:
- Update priority at each clk_2 rising edge: reset==0, then load, then enable. With none of these active, all state holds.
- Reset (reset==0): count=0, wrap=0. Reset also applies mid-count and mid-load.
- Load: each digit takes its data_in field. Any field >= MODULUS is clamped to MODULUS-1 per digit. Load sets wrap=0. Load ignores enable, count_up and saturate.
- Up count (enable=1, count_up=1):
  - Digit 0 always steps.
  - Digit i>0 steps only when all lower digits == MODULUS-1.
  - A digit step is v -> v+1, except MODULUS-1 -> 0.
- Down count (enable=1, count_up=0):
  - Digit 0 always steps.
  - Digit i>0 steps only when all lower digits == 0.
  - A digit step is v -> v-1, except 0 -> MODULUS-1.
- Terminal value:
  - Up: every digit == MODULUS-1.
  - Down: every digit == 0.
- terminal = 1 whenever count equals the terminal value for the current count_up. It is combinational from count and count_up, with no enable qualification.
- Saturate mode (saturate=1): enable at the terminal value leaves count unchanged and sets wrap=0.
- Wrap mode (saturate=0): enable at the terminal value wraps the full counter (all MODULUS-1 -> all 0 going up; all 0 -> all MODULUS-1 going down).
- wrap is registered at the same edge as the wrap-around, so it is 1 during exactly the cycle in which count shows the wrapped value. On any other edge, wrap=0.
- Changes to count_up or saturate take effect at the next enabled edge. There are no intermediate or glitch values on count.
- Latency: one clk_2 edge from a load or enable to the updated count.
- No state is held other than count and wrap. Every digit stays in 0..MODULUS-1 at all times after reset.

Optional Feature:
Macro SEG7_DISPLAY_EN.
- Defined: adds output port seg, 8 bits, combinationally decoded from digit 0.
  - seg[6:0] is the active-high seven-segment pattern (a=bit0 .. g=bit6) for hex 0..F.
  - seg[7] (decimal point) = wrap.
  - After reset, seg = 8'h3F (digit "0", dp off).
- Undefined: port seg does not exist, and no decode logic is built. Counting behaviour is identical in both builds.

Test Plan:
All scenarios use NDIGITS=2, MODULUS=10, DIGIT_W=4.
1. reset=0 for 1 edge with load=1 and enable=1 -> count=8'h00, wrap=0, terminal=0 (count_up=1).
2. load=1, data_in=8'h38, then enable=1, count_up=1, saturate=0 for 2 edges -> count 8'h39 then 8'h40, wrap=0 throughout.
3. load 8'h99, then enable up with saturate=0 -> count=8'h00 and wrap=1 for exactly one cycle; next edge -> count=8'h01, wrap=0.
4. load 8'h00, count_up=0, saturate=0, enable for 1 edge -> count=8'h99, wrap=1. Repeat with saturate=1 from 8'h00 for 3 edges -> count stays 8'h00, terminal=1, wrap=0.
5. load data_in=8'hC7 -> count=8'h97 (upper digit clamped to 9). Load asserted together with enable -> load wins.
6. Count up from 8'h05; drive reset=0 for one edge while enable=1 -> count=8'h00 at that edge and wrap=0. Releasing reset resumes counting to 8'h01 on the next edge.
